dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: port 0 (core load/store unit) and port 1 (program/data loader).
- Performs all sub-word handling itself. Toward memory it only issues word-wide reads and writes (funct3 = 3'b010).
- Byte and halfword stores are done as a read-modify-write sequence.
- Load results are extracted and sign/zero-extended before they are returned to the requester.

Parameters:
- ADDR_W, 12: requester byte-address width. The memory word index is ADDR_W-2 = 10 bits.
- RESET_PRIO, 0: requester that wins the first contested arbitration after reset.

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  2  per-requester request valid ([0] core, [1] loader)
- req_ready  out  2  per-requester accept; at most one bit set
- req_we0 / req_we1  in  1  1 = store, 0 = load
- req_funct3_0 / _1  in  3  RV32I width code: 000 b, 001 h, 010 w, 100 bu, 101 hu
- req_addr0 / _1  in  ADDR_W  byte address
- req_wdata0 / _1  in  32  store data, right-aligned
- rsp_valid  out  1  one-cycle response pulse
- rsp_id  out  1  requester the response belongs to
- rsp_rdata  out  32  load result, extended; 0 for stores
- rsp_err  out  1  misaligned or illegal funct3; no memory write occurred
- mem_we  out  1  memory write enable
- mem_funct3  out  3  constant 3'b010
- mem_addr  out  ADDR_W-2  word index = byte address [ADDR_W-1:2]
- mem_wdata  out  32  full word to write
- mem_rdata  in  32  combinational word read of mem_addr

Behaviour:
- Reset (async, immediate): state IDLE, req_ready=0, rsp_valid=0, rsp_id=0, rsp_rdata=0, rsp_err=0, mem_we=0, mem_addr=0, mem_wdata=0, rr pointer=RESET_PRIO.
- Reset mid-operation: any in-flight access is aborted, mem_we drops at once, and no response is issued.
- FSM states: IDLE, ACCESS, RMW_WR, RESP.
- IDLE arbitration:
  - req_ready is combinational: exactly one valid requester is granted.
  - With both valid, the winner is the requester the rr pointer selects. The pointer then flips to the other one (round-robin).
  - Handshake = req_valid[i] & req_ready[i]. On a handshake, we/funct3/addr/wdata/id are registered and the FSM goes to ACCESS.
  - req_ready is 0 in every state except IDLE.
- Error check (at handshake):
  - funct3 not in {000,001,010,100,101}, or store with funct3 in {100,101} → error.
  - h/hu with addr[0]=1 → error.
  - w with addr[1:0]≠0 → error.
  - An error goes directly to RESP with rsp_err=1, rsp_rdata=0, and never asserts mem_we.
- ACCESS (mem_addr = registered word index):
  - Load: capture the lane selected by addr[1:0]. b: sign-extend byte; bu: zero-extend byte; h: sign-extend halfword; hu: zero-extend halfword; w: full word. Then go to RESP.
  - sw: mem_we=1, mem_wdata=wdata. Then go to RESP.
  - sb/sh: mem_we=0. Merge the byte (lane addr[1:0]) or halfword (lane addr[1]) into mem_rdata, register the merged word, then go to RMW_WR.
- RMW_WR: mem_we=1, mem_wdata=merged word, then go to RESP.
- RESP: rsp_valid=1 for exactly one cycle with the registered id/rdata/err, then IDLE. There is no response backpressure.
- Latency, handshake edge → rsp_valid: load 2 cycles, sw 2 cycles, sb/sh 3 cycles, error 1 cycle.
- Throughput: the earliest next handshake is the cycle after RESP. A requester whose valid stays high while the other is being served waits; it is never dropped.
- mem_we is asserted for exactly one cycle per successful store and is 0 in IDLE and RESP.

Decomposition:
- Shared package (dmem_pkg): funct3 codes (F3_B, F3_H, F3_W, F3_BU, F3_HU), state encoding, a lane-merge function and a load-extend function.
- Sub-module lane_unit: combinational merge (old word, wdata, offset, size → new word) and extract (word, offset, funct3 → result). It is shared by the store and load paths.

Test Plan:
- Core sw 0xDEADBEEF @0x010, then lw @0x010 → mem_we one pulse at idx 4; load rsp_rdata=0xDEADBEEF, 2 cycles after handshake.
- Word 0x11223344 preloaded @0x020; core sb 0xAB @0x022 → one read, then a write of 0x11AB3344. Subsequent lb @0x022 → 0xFFFFFFAB; lbu → 0x000000AB.
- sh 0x8001 @0x026 onto 0 → word 0x80010000; lh → 0xFFFF8001; lhu → 0x00008001.
- lw @0x013, sh @0x031, sb with funct3 100 → rsp_err=1 one cycle after handshake; no mem_we; memory unchanged.
- Both requesters valid every cycle → grants alternate 0,1,0,1 starting with RESET_PRIO; rsp_id matches; no starvation.
- rst_n low during RMW_WR of sb → mem_we low immediately, no rsp_valid, target word unchanged; after release, the FSM is in IDLE and accepts the next request.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: RV32I width codes, FSM
// state encoding and the sub-word merge / load-extend / legality helpers.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RMW_WR,
    ST_RESP
  } state_t;

  // Drops a byte (lane = offset) or halfword (lane = offset[1]) into a word.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                             input logic [15:0] wdata,
                                             input logic [1:0]  offset,
                                             input logic        is_half);
    logic [31:0] merged;
    merged = old_word;
    if (is_half) begin
      if (offset[1]) merged[31:16] = wdata;
      else           merged[15:0]  = wdata;
    end else begin
      case (offset)
        2'd0:    merged[7:0]   = wdata[7:0];
        2'd1:    merged[15:8]  = wdata[7:0];
        2'd2:    merged[23:16] = wdata[7:0];
        default: merged[31:24] = wdata[7:0];
      endcase
    end
    return merged;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  offset,
                                              input logic [2:0]  funct3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] result;
    case (offset)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = offset[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    result = {{24{b[7]}}, b};
      F3_BU:   result = {24'd0, b};
      F3_H:    result = {{16{h[15]}}, h};
      F3_HU:   result = {16'd0, h};
      default: result = word;
    endcase
    return result;
  endfunction

  // Unsigned codes are load-only; halfwords need even and words aligned addresses.
  function automatic logic access_err(input logic       we,
                                      input logic [2:0] funct3,
                                      input logic [1:0] addr_lo);
    logic err;
    case (funct3)
      F3_B:    err = 1'b0;
      F3_BU:   err = we;
      F3_H:    err = addr_lo[0];
      F3_HU:   err = we | addr_lo[0];
      F3_W:    err = (addr_lo != 2'b00);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester, response and word-memory bundle of the data-memory arbiter.
// master = requesters plus memory model, slave = the arbiter.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 12
);

  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic              req_we0;
  logic              req_we1;
  logic [2:0]        req_funct3_0;
  logic [2:0]        req_funct3_1;
  logic [ADDR_W-1:0] req_addr0;
  logic [ADDR_W-1:0] req_addr1;
  logic [31:0]       req_wdata0;
  logic [31:0]       req_wdata1;

  logic              rsp_valid;
  logic              rsp_id;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  logic              mem_we;
  logic [2:0]        mem_funct3;
  logic [ADDR_W-3:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport master (
    output req_valid, req_we0, req_we1, req_funct3_0, req_funct3_1,
           req_addr0, req_addr1, req_wdata0, req_wdata1, mem_rdata,
    input  req_ready, rsp_valid, rsp_id, rsp_rdata, rsp_err,
           mem_we, mem_funct3, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_we0, req_we1, req_funct3_0, req_funct3_1,
           req_addr0, req_addr1, req_wdata0, req_wdata1, mem_rdata,
    output req_ready, rsp_valid, rsp_id, rsp_rdata, rsp_err,
           mem_we, mem_funct3, mem_addr, mem_wdata
  );

endinterface

// File: rtl/lane_unit.sv
// Combinational sub-word datapath shared by the store (merge) and load
// (extract + extend) paths; both operate on the word currently read from memory.
module lane_unit
  import dmem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [15:0] i_wdata,
  input  logic [1:0]  i_offset,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_merged,
  output logic [31:0] o_loaded
);

  // funct3[0] separates halfword from byte for the two legal sub-word stores.
  assign o_merged = lane_merge(i_word, i_wdata, i_offset, i_funct3[0]);
  assign o_loaded = load_extend(i_word, i_offset, i_funct3);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of a word-wide single-port
// memory; sub-word stores become read-modify-write, loads are extended here.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int RESET_PRIO = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  bus
);

  state_t            r_state;
  state_t            w_next;
  logic              r_rr;
  logic              r_id;
  logic              r_we;
  logic              r_err;
  logic [2:0]        r_f3;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic [31:0]       r_merged;

  logic [1:0]        w_grant;
  logic              w_contested;
  logic              w_hs;
  logic              w_sel;
  logic              w_we;
  logic [2:0]        w_f3;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_wdata;
  logic              w_err;
  logic              w_mem_we;
  logic [31:0]       w_mem_wdata;
  logic [31:0]       w_merged;
  logic [31:0]       w_loaded;

  assign w_hs    = |w_grant;
  assign w_sel   = w_grant[1];
  assign w_we    = w_sel ? bus.req_we1      : bus.req_we0;
  assign w_f3    = w_sel ? bus.req_funct3_1 : bus.req_funct3_0;
  assign w_addr  = w_sel ? bus.req_addr1    : bus.req_addr0;
  assign w_wdata = w_sel ? bus.req_wdata1   : bus.req_wdata0;
  assign w_err   = access_err(w_we, w_f3, w_addr[1:0]);

  lane_unit u_lane (
    .i_word   (bus.mem_rdata),
    .i_wdata  (r_wdata[15:0]),
    .i_offset (r_addr[1:0]),
    .i_funct3 (r_f3),
    .o_merged (w_merged),
    .o_loaded (w_loaded)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Errors skip memory entirely; only byte/halfword stores need the extra write cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_hs) w_next = w_err ? ST_RESP : ST_ACCESS;
      ST_ACCESS: w_next = (r_we && (r_f3 != F3_W)) ? ST_RMW_WR : ST_RESP;
      ST_RMW_WR: w_next = ST_RESP;
      ST_RESP:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_grant     = 2'b00;
    w_contested = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_wdata = r_wdata;
    case (r_state)
      ST_IDLE: begin
        case (bus.req_valid)
          2'b01:   w_grant = 2'b01;
          2'b10:   w_grant = 2'b10;
          2'b11: begin
            w_contested = 1'b1;
            w_grant     = r_rr ? 2'b10 : 2'b01;
          end
          default: w_grant = 2'b00;
        endcase
      end
      ST_ACCESS: w_mem_we = r_we && (r_f3 == F3_W);
      ST_RMW_WR: begin
        w_mem_we    = 1'b1;
        w_mem_wdata = r_merged;
      end
      default: ;
    endcase
  end

  // The rr pointer only moves on contested grants, so it always names the next loser's turn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr     <= 1'(RESET_PRIO);
      r_id     <= 1'b0;
      r_we     <= 1'b0;
      r_err    <= 1'b0;
      r_f3     <= 3'b000;
      r_addr   <= '0;
      r_wdata  <= 32'd0;
      r_rdata  <= 32'd0;
      r_merged <= 32'd0;
    end else if (w_hs) begin
      r_id    <= w_sel;
      r_we    <= w_we;
      r_err   <= w_err;
      r_f3    <= w_f3;
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
      r_rdata <= 32'd0;
      if (w_contested) r_rr <= ~w_sel;
    end else if (r_state == ST_ACCESS) begin
      if (r_we) r_merged <= w_merged;
      else      r_rdata  <= w_loaded;
    end
  end

  assign bus.req_ready  = w_grant;
  assign bus.rsp_valid  = (r_state == ST_RESP);
  assign bus.rsp_id     = r_id;
  assign bus.rsp_rdata  = r_rdata;
  assign bus.rsp_err    = r_err;
  assign bus.mem_we     = w_mem_we;
  assign bus.mem_funct3 = F3_W;
  assign bus.mem_addr   = r_addr[ADDR_W-1:2];
  assign bus.mem_wdata  = w_mem_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: word-memory model, response scoreboard with latency
// tracking, and directed store/load/error/arbitration/reset scenarios.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int ADDR_W = 12;

  typedef struct {
    logic        id;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  logic clk;
  logic rst_n;

  dmem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  dmem_arbiter #(.ADDR_W(ADDR_W), .RESET_PRIO(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem [1024];
  logic        loadEn;
  logic [9:0]  loadIdx;
  logic [31:0] loadData;
  logic [9:0]  lastWeIdx;
  exp_t        expQ[$];
  int          totalCount = 0;
  int          badCount   = 0;
  int          cycleCnt   = 0;
  int          hsCycle    = 0;
  int          hsCount    = 0;
  int          weCount    = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign bus.mem_rdata = mem[bus.mem_addr];

  // Everything that happens on a rising edge is sampled 1ns before it,
  // so the bench never races the DUT's own state update.
  always @(negedge clk) begin
    logic        preHs, preWe, preLoad;
    logic [9:0]  preIdx, preLoadIdx;
    logic [31:0] preData, preLoadData;
    #4;
    preHs       = rst_n && |(bus.req_valid & bus.req_ready);
    preWe       = bus.mem_we;
    preIdx      = bus.mem_addr;
    preData     = bus.mem_wdata;
    preLoad     = loadEn;
    preLoadIdx  = loadIdx;
    preLoadData = loadData;
    @(posedge clk);
    cycleCnt++;
    if (preHs) begin
      hsCycle = cycleCnt;
      hsCount++;
    end
    if (preLoad) mem[preLoadIdx] = preLoadData;
    else if (preWe) begin
      mem[preIdx] = preData;
      weCount++;
      lastWeIdx = preIdx;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    totalCount++;
    if (actual !== expected) begin
      badCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Scoreboard: every response pops the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1)
      checkOutput("ready onehot", {31'd0, bus.req_ready[0] & bus.req_ready[1]}, 32'd0);
    if (bus.rsp_valid === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("rsp_id", {31'd0, bus.rsp_id}, {31'd0, e.id});
        checkOutput("rsp_rdata", bus.rsp_rdata, e.rdata);
        checkOutput("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e.err});
        checkOutput("latency", 32'(cycleCnt - hsCycle + 1), 32'(e.lat));
      end
    end
  end

  task automatic preload(input logic [9:0] idx, input logic [31:0] data);
    @(negedge clk);
    loadEn   = 1'b1;
    loadIdx  = idx;
    loadData = data;
    @(negedge clk);
    loadEn   = 1'b0;
  endtask

  task automatic driveReq(input int port, input logic we, input logic [2:0] f3,
                          input logic [ADDR_W-1:0] addr, input logic [31:0] wdata);
    if (port == 0) begin
      bus.req_we0      = we;
      bus.req_funct3_0 = f3;
      bus.req_addr0    = addr;
      bus.req_wdata0   = wdata;
    end else begin
      bus.req_we1      = we;
      bus.req_funct3_1 = f3;
      bus.req_addr1    = addr;
      bus.req_wdata1   = wdata;
    end
    bus.req_valid[port] = 1'b1;
  endtask

  task automatic pushExp(input int port, input logic [31:0] rdata, input logic err, input int lat);
    exp_t e;
    e.id    = port[0];
    e.rdata = rdata;
    e.err   = err;
    e.lat   = lat;
    expQ.push_back(e);
  endtask

  task automatic waitGrant(input int port);
    int guard = 0;
    #1;
    while (bus.req_ready[port] !== 1'b1 && guard < 20) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (guard >= 20) checkOutput("grant wait", {31'd0, bus.req_ready[port]}, 32'd1);
  endtask

  task automatic waitDrain();
    int guard = 0;
    while (expQ.size() != 0 && guard < 20) begin
      @(negedge clk);
      #2;
      guard++;
    end
    if (expQ.size() != 0) begin
      checkOutput("response timeout", 32'(expQ.size()), 32'd0);
      expQ.delete();
    end
    @(negedge clk);
  endtask

  task automatic applyStimulus(input int port, input logic we, input logic [2:0] f3,
                               input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                               input logic [31:0] expRdata, input logic expErr, input int expLat);
    pushExp(port, expRdata, expErr, expLat);
    driveReq(port, we, f3, addr, wdata);
    waitGrant(port);
    @(negedge clk);
    bus.req_valid[port] = 1'b0;
    waitDrain();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int weBase;
    int hsBase;
    int guard;

    rst_n            = 1'b1;
    loadEn           = 1'b0;
    loadIdx          = 10'd0;
    loadData         = 32'd0;
    bus.req_valid    = 2'b00;
    bus.req_we0      = 1'b0;
    bus.req_we1      = 1'b0;
    bus.req_funct3_0 = 3'b000;
    bus.req_funct3_1 = 3'b000;
    bus.req_addr0    = '0;
    bus.req_addr1    = '0;
    bus.req_wdata0   = 32'd0;
    bus.req_wdata1   = 32'd0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset req_ready", {30'd0, bus.req_ready}, 32'd0);
    checkOutput("reset rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    checkOutput("reset rsp id/err", {30'd0, bus.rsp_id, bus.rsp_err}, 32'd0);
    checkOutput("reset rsp_rdata", bus.rsp_rdata, 32'd0);
    checkOutput("reset mem_we", {31'd0, bus.mem_we}, 32'd0);
    checkOutput("reset mem_addr", {22'd0, bus.mem_addr}, 32'd0);
    checkOutput("reset mem_wdata", bus.mem_wdata, 32'd0);

    preload(10'd4,  32'h0000_0000);
    preload(10'd8,  32'h1122_3344);
    preload(10'd9,  32'h0000_0000);
    preload(10'd16, 32'h5566_7788);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] word store and load");
    weBase = weCount;
    applyStimulus(0, 1'b1, F3_W, 12'h010, 32'hDEAD_BEEF, 32'd0, 1'b0, 2);
    checkOutput("sw we pulses", 32'(weCount - weBase), 32'd1);
    checkOutput("sw word index", {22'd0, lastWeIdx}, 32'd4);
    checkOutput("sw mem word", mem[4], 32'hDEAD_BEEF);
    applyStimulus(0, 1'b0, F3_W, 12'h010, 32'd0, 32'hDEAD_BEEF, 1'b0, 2);

    $display("[TB] byte store read-modify-write");
    weBase = weCount;
    applyStimulus(0, 1'b1, F3_B, 12'h022, 32'h0000_00AB, 32'd0, 1'b0, 3);
    checkOutput("sb we pulses", 32'(weCount - weBase), 32'd1);
    checkOutput("sb word index", {22'd0, lastWeIdx}, 32'd8);
    checkOutput("sb mem word", mem[8], 32'h11AB_3344);
    applyStimulus(0, 1'b0, F3_B,  12'h022, 32'd0, 32'hFFFF_FFAB, 1'b0, 2);
    applyStimulus(0, 1'b0, F3_BU, 12'h022, 32'd0, 32'h0000_00AB, 1'b0, 2);

    $display("[TB] halfword store read-modify-write");
    weBase = weCount;
    applyStimulus(0, 1'b1, F3_H, 12'h026, 32'h0000_8001, 32'd0, 1'b0, 3);
    checkOutput("sh we pulses", 32'(weCount - weBase), 32'd1);
    checkOutput("sh mem word", mem[9], 32'h8001_0000);
    applyStimulus(0, 1'b0, F3_H,  12'h026, 32'd0, 32'hFFFF_8001, 1'b0, 2);
    applyStimulus(0, 1'b0, F3_HU, 12'h026, 32'd0, 32'h0000_8001, 1'b0, 2);
    applyStimulus(1, 1'b0, F3_W,  12'h024, 32'd0, 32'h8001_0000, 1'b0, 2);

    $display("[TB] illegal accesses");
    weBase = weCount;
    applyStimulus(0, 1'b0, F3_W,   12'h013, 32'd0,         32'd0, 1'b1, 1);
    applyStimulus(0, 1'b1, F3_H,   12'h031, 32'h0000_1234, 32'd0, 1'b1, 1);
    applyStimulus(0, 1'b1, F3_BU,  12'h020, 32'h0000_0055, 32'd0, 1'b1, 1);
    applyStimulus(1, 1'b0, 3'b011, 12'h020, 32'd0,         32'd0, 1'b1, 1);
    checkOutput("error we pulses", 32'(weCount - weBase), 32'd0);
    checkOutput("error mem word", mem[8], 32'h11AB_3344);

    $display("[TB] contested round-robin");
    pushExp(0, 32'hDEAD_BEEF, 1'b0, 2);
    pushExp(1, 32'h11AB_3344, 1'b0, 2);
    pushExp(0, 32'hDEAD_BEEF, 1'b0, 2);
    pushExp(1, 32'h11AB_3344, 1'b0, 2);
    hsBase = hsCount;
    driveReq(0, 1'b0, F3_W, 12'h010, 32'd0);
    driveReq(1, 1'b0, F3_W, 12'h020, 32'd0);
    guard = 0;
    while (hsCount < hsBase + 4 && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    bus.req_valid = 2'b00;
    checkOutput("contested handshakes", 32'(hsCount - hsBase), 32'd4);
    waitDrain();

    $display("[TB] reset during read-modify-write");
    weBase = weCount;
    driveReq(0, 1'b1, F3_B, 12'h040, 32'h0000_00CC);
    waitGrant(0);
    @(negedge clk);
    bus.req_valid = 2'b00;
    @(negedge clk);
    checkOutput("rmw we before reset", {31'd0, bus.mem_we}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("we after reset", {31'd0, bus.mem_we}, 32'd0);
    checkOutput("rsp_valid after reset", {31'd0, bus.rsp_valid}, 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("aborted we pulses", 32'(weCount - weBase), 32'd0);
    checkOutput("aborted mem word", mem[16], 32'h5566_7788);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(0, 1'b0, F3_W, 12'h040, 32'd0, 32'h5566_7788, 1'b0, 2);

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
